// File: rtl/tfcall_sched.sv
// tfcall_sched: round-robin scheduler that shares one multi-cycle function
// unit between NREQ requesters. It grants one call at a time, runs the unit
// for LAT cycles and returns the result tagged with the caller's index.
// Optional feature: define TFCALL_SCHED_ERRCNT_EN to add the saturating
// illegal-call counter output err_cnt.
module tfcall_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int LAT  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [2*NREQ-1:0]        req_op,
  input  logic [W*NREQ-1:0]        req_a,
  input  logic [W*NREQ-1:0]        req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [W-1:0]             rsp_data,
  output logic                     rsp_err,
`ifdef TFCALL_SCHED_ERRCNT_EN
  output logic [7:0]               err_cnt,
`endif
  output logic                     busy
);

  localparam int IW = $clog2(NREQ);

  localparam logic [1:0] OP_SUM     = 2'd0;
  localparam logic [1:0] OP_DOUBLE  = 2'd1;
  localparam logic [1:0] OP_CONST   = 2'd2;
  localparam logic [1:0] OP_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [IW-1:0] ptr;
  logic [IW-1:0] grant;
  logic          grant_vld;
  logic [1:0]    grant_op;
  logic [W-1:0]  grant_a;
  logic [W-1:0]  grant_b;
  logic [IW-1:0] ptr_nxt;
  logic          accept;
  logic          last_exec;

  logic [1:0]    op_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [3:0]    cnt;
  logic [W-1:0]  result;

  // Round-robin search: the first valid requester at or after ptr wins.
  // Walking offsets downward lets the smallest offset overwrite the others.
  always_comb begin
    int j;
    grant     = '0;
    grant_vld = 1'b0;
    j         = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NREQ) begin
        j = j - NREQ;
      end
      if (req_valid[IW'(j)]) begin
        grant     = IW'(j);
        grant_vld = 1'b1;
      end
    end
  end

  // Select the winning requester's opcode and operands out of the packed buses.
  always_comb begin
    grant_op = '0;
    grant_a  = '0;
    grant_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IW'(i)) begin
        grant_op = req_op[2*i +: 2];
        grant_a  = req_a[W*i +: W];
        grant_b  = req_b[W*i +: W];
      end
    end
  end

  assign ptr_nxt   = (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;
  assign accept    = (state == IDLE) && grant_vld;
  assign last_exec = (cnt == 4'(LAT - 1));

  // Shared function unit: results are truncated to W bits, no overflow flag.
  always_comb begin
    result = '0;
    case (op_q)
      OP_SUM:    result = a_q + b_q;
      OP_DOUBLE: result = {a_q[W-2:0], 1'b0};
      OP_CONST:  result = W'(1);
      default:   result = '0;
    endcase
  end

  // State register; reset abandons any call in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; req_ready is only raised while idle.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (grant_vld) begin
          req_ready[grant] = 1'b1;
          state_nxt = (grant_op == OP_ILLEGAL) ? RESP : EXEC;
        end
      end
      EXEC: begin
        if (last_exec) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Call latch, latency counter and response registers; the response fields
  // only change at accept or at the end of execution, so they hold in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt      <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            op_q   <= grant_op;
            a_q    <= grant_a;
            b_q    <= grant_b;
            cnt    <= '0;
            rsp_id <= grant;
            ptr    <= ptr_nxt;
            if (grant_op == OP_ILLEGAL) begin
              rsp_data <= '0;
              rsp_err  <= 1'b1;
            end else begin
              rsp_err  <= 1'b0;
            end
          end
        end
        EXEC: begin
          if (last_exec) begin
            rsp_data <= result;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef TFCALL_SCHED_ERRCNT_EN
  // Count accepted illegal calls, saturating at 255; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (accept && (grant_op == OP_ILLEGAL) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tfcall_sched.sv
// tb_tfcall_sched: directed self-checking bench for tfcall_sched
// (NREQ=4, W=8, LAT=2). Define TFCALL_SCHED_ERRCNT_EN to also check err_cnt.
module tb_tfcall_sched;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int LAT  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [2*NREQ-1:0] req_op;
  logic [W*NREQ-1:0] req_a;
  logic [W*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_data;
  logic              rsp_err;
  logic              busy;
`ifdef TFCALL_SCHED_ERRCNT_EN
  logic [7:0]        err_cnt;
`endif

  int checks;
  int errors;

  tfcall_sched #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
`ifdef TFCALL_SCHED_ERRCNT_EN
    .err_cnt   (err_cnt),
`endif
    .busy      (busy)
  );

  // Free-running clock, rising edge active.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Load one requester's opcode and operands into the packed buses.
  task automatic applyStimulus(input int idx, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op[2*idx +: 2] = op;
    req_a[W*idx +: W]  = a;
    req_b[W*idx +: W]  = b;
  endtask

  // Pulse reset across one negedge-to-negedge interval.
  task automatic doReset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Wait (at negedges) for rsp_valid, bounded; an expired bound is a failure.
  task automatic waitResp(input int max_cyc, output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
    end
    if (!rsp_valid) begin
      checkOutput("rsp_timeout", 32'(rsp_valid), 32'd1);
    end
  endtask

  initial begin
    int cyc;
    int n;
    int guard;
    bit seen;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // Reset state
    #1;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_id",    32'(rsp_id),    32'd0);
    checkOutput("rst_rsp_data",  32'(rsp_data),  32'd0);
    checkOutput("rst_rsp_err",   32'(rsp_err),   32'd0);
    checkOutput("rst_busy",      32'(busy),      32'd0);
`ifdef TFCALL_SCHED_ERRCNT_EN
    checkOutput("rst_err_cnt",   32'(err_cnt),   32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Requester 1 SUM 1+2
    applyStimulus(1, 2'd0, 8'd1, 8'd2);
    req_valid = 4'b0010;
    #1;
    checkOutput("t1_req_ready", 32'(req_ready), 32'b0010);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    checkOutput("t1_ready_after", 32'(req_ready), 32'd0);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    checkOutput("t1_no_rsp_yet", 32'(rsp_valid), 32'd0);
    waitResp(10, cyc);
    checkOutput("t1_latency", 32'(cyc), 32'(LAT));
    checkOutput("t1_rsp_id",   32'(rsp_id),   32'd1);
    checkOutput("t1_rsp_data", 32'(rsp_data), 32'd3);
    checkOutput("t1_rsp_err",  32'(rsp_err),  32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("t1_rsp_done", 32'(rsp_valid), 32'd0);
    checkOutput("t1_idle",     32'(busy),      32'd0);

    // All four DOUBLE 0x81 continuously: ids rotate, data truncates to 0x02
    doReset();
    for (int i = 0; i < NREQ; i++) begin
      applyStimulus(i, 2'd1, 8'h81, 8'h00);
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      waitResp(20, cyc);
      checkOutput($sformatf("t2_period_%0d", k), 32'(cyc), 32'(LAT + 1));
      checkOutput($sformatf("t2_id_%0d", k),     32'(rsp_id),   32'(k % NREQ));
      checkOutput($sformatf("t2_data_%0d", k),   32'(rsp_data), 32'h02);
      checkOutput($sformatf("t2_err_%0d", k),    32'(rsp_err),  32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);

    // Requester 2 ILLEGAL: response right after accept
    doReset();
    applyStimulus(2, 2'd3, 8'h12, 8'h34);
    req_valid = 4'b0100;
    #1;
    checkOutput("t3_req_ready", 32'(req_ready), 32'b0100);
    @(posedge clk);
    @(negedge clk);
    checkOutput("t3_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("t3_rsp_err",   32'(rsp_err),   32'd1);
    checkOutput("t3_rsp_data",  32'(rsp_data),  32'd0);
    checkOutput("t3_rsp_id",    32'(rsp_id),    32'd2);
`ifdef TFCALL_SCHED_ERRCNT_EN
    checkOutput("t3_err_cnt_1", 32'(err_cnt), 32'd1);
    n = 1;
    guard = 0;
    while (n < 300 && guard < 1000) begin
      @(posedge clk);
      @(negedge clk);
      guard++;
      if (rsp_valid) begin
        n++;
      end
    end
    checkOutput("t3_illegal_calls", 32'(n), 32'd300);
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t3_err_cnt_sat", 32'(err_cnt), 32'd255);
`else
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
`endif

    // CONST from requester 3 with rsp_ready held low
    doReset();
    rsp_ready = 1'b0;
    applyStimulus(3, 2'd2, 8'h55, 8'hAA);
    req_valid = 4'b1000;
    #1;
    checkOutput("t4_req_ready", 32'(req_ready), 32'b1000);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(0, 2'd0, 8'hF0, 8'h20);
    req_valid = 4'b0001;
    checkOutput("t4_ready_exec", 32'(req_ready), 32'd0);
    waitResp(10, cyc);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("t4_hold_valid_%0d", k), 32'(rsp_valid), 32'd1);
      checkOutput($sformatf("t4_hold_data_%0d", k),  32'(rsp_data),  32'd1);
      checkOutput($sformatf("t4_hold_id_%0d", k),    32'(rsp_id),    32'd3);
      checkOutput($sformatf("t4_hold_ready_%0d", k), 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t4_rsp_done",  32'(rsp_valid), 32'd0);
    checkOutput("t4_grant_req0", 32'(req_ready), 32'b0001);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    waitResp(10, cyc);
    checkOutput("t4_sum_id",   32'(rsp_id),   32'd0);
    checkOutput("t4_sum_wrap", 32'(rsp_data), 32'h10);
    @(posedge clk);
    @(negedge clk);

    // Reset pulsed during EXEC: call abandoned, pointer back to requester 0
    doReset();
    applyStimulus(1, 2'd0, 8'd7, 8'd9);
    req_valid = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    checkOutput("t5_busy_exec", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_busy_rst",  32'(busy),      32'd0);
    checkOutput("t5_valid_rst", 32'(rsp_valid), 32'd0);
    checkOutput("t5_id_rst",    32'(rsp_id),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
      end
    end
    checkOutput("t5_no_rsp", 32'(seen), 32'd0);
    for (int i = 0; i < NREQ; i++) begin
      applyStimulus(i, 2'd2, 8'h00, 8'h00);
    end
    req_valid = 4'b1111;
    #1;
    checkOutput("t5_grant_req0", 32'(req_ready), 32'b0001);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    waitResp(10, cyc);
    checkOutput("t5_rsp_id",   32'(rsp_id),   32'd0);
    checkOutput("t5_rsp_data", 32'(rsp_data), 32'd1);
    @(posedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
